alu_issue: RTL

- Producer and consumer end of the ALU operand/result interface.
- Accepts one 32-bit RV32I OP/OP-IMM instruction per handshake and reads rs1/rs2 from an internal 32x32 register file.
- Decodes immediates and drives lhs/rhs/funct3/funct7 with per-field valids into the combinational ALU.
- Captures the result, writes rd and signals retirement.
- Sits between the fetch stage and the ALU. Blocking, single-issue, so it needs no hazard logic.

---
 rtl/alu_issue.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/alu_issue.sv
// Single-issue RV32I OP/OP-IMM front end: owns the register file, feeds the
// external combinational ALU for one cycle and retires the result.
//
// state  | meaning
// IDLE   | waiting for an instruction, instr_ready high
// ISSUE  | latched word decoded onto the ALU buses; result sampled at the edge
// RETIRE | retire pulse with registered rd/value/illegal
module alu_issue #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_COUNT  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           instr,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    output logic [DATA_WIDTH-1:0] lhs,
    output logic                  lhs_valid,
    output logic [DATA_WIDTH-1:0] rhs,
    output logic                  rhs_valid,
    output logic [2:0]            operation,
    output logic                  operation_valid,
    output logic [6:0]            metadata,
    output logic                  metadata_valid,
    input  logic [DATA_WIDTH-1:0] result,
    input  logic                  result_valid,
    output logic                  retire_valid,
    output logic                  retire_illegal,
    output logic [4:0]            retire_rd,
    output logic [DATA_WIDTH-1:0] retire_value,
    input  logic [4:0]            dbg_addr,
    output logic [DATA_WIDTH-1:0] dbg_data
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        RETIRE = 2'd2
    } state_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    state_t                state;
    state_t                state_nxt;
    logic [31:0]           instr_q;
    logic [DATA_WIDTH-1:0] regs [REG_COUNT];

    logic [6:0]            opcode;
    logic [4:0]            rd;
    logic [2:0]            funct3;
    logic [4:0]            rs1;
    logic [4:0]            rs2;
    logic [6:0]            funct7;
    logic                  is_op;
    logic                  is_op_imm;
    logic                  is_shift;
    logic [DATA_WIDTH-1:0] rs1_val;
    logic [DATA_WIDTH-1:0] rs2_val;

    assign opcode    = instr_q[6:0];
    assign rd        = instr_q[11:7];
    assign funct3    = instr_q[14:12];
    assign rs1       = instr_q[19:15];
    assign rs2       = instr_q[24:20];
    assign funct7    = instr_q[31:25];
    assign is_op     = (opcode == OPC_OP);
    assign is_op_imm = (opcode == OPC_OP_IMM);
    assign is_shift  = (funct3 == 3'd1) || (funct3 == 3'd5);

    // x0 is never written, but reads are masked so it is zero by construction
    assign rs1_val  = (rs1 == 5'd0) ? '0 : regs[rs1];
    assign rs2_val  = (rs2 == 5'd0) ? '0 : regs[rs2];
    assign dbg_data = (dbg_addr == 5'd0) ? '0 : regs[dbg_addr];

    always_comb begin
        state_nxt       = state;
        instr_ready     = 1'b0;
        lhs             = '0;
        rhs             = '0;
        operation       = '0;
        metadata        = '0;
        lhs_valid       = 1'b0;
        rhs_valid       = 1'b0;
        operation_valid = 1'b0;
        metadata_valid  = 1'b0;
        retire_valid    = 1'b0;
        case (state)
            IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                state_nxt = RETIRE;
                if (is_op || is_op_imm) begin
                    lhs             = rs1_val;
                    operation       = funct3;
                    lhs_valid       = 1'b1;
                    rhs_valid       = 1'b1;
                    operation_valid = 1'b1;
                    metadata_valid  = 1'b1;
                    if (is_op) begin
                        rhs      = is_shift ? {27'd0, rs2_val[4:0]} : rs2_val;
                        metadata = funct7;
                    end else if (is_shift) begin
                        rhs      = {27'd0, rs2};
                        metadata = funct7;
                    end else begin
                        rhs      = {{20{instr_q[31]}}, instr_q[31:20]};
                        metadata = 7'h00;
                    end
                end
            end
            RETIRE: begin
                retire_valid = 1'b1;
                state_nxt    = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            instr_q        <= '0;
            retire_illegal <= 1'b0;
            retire_rd      <= '0;
            retire_value   <= '0;
            regs           <= '{default: '0};
        end else begin
            state <= state_nxt;
            if (state == IDLE && instr_valid) begin
                instr_q <= instr;
            end
            if (state == ISSUE) begin
                retire_rd <= rd;
                // an unknown opcode never commits, whatever the ALU claims
                if (result_valid && (is_op || is_op_imm)) begin
                    if (rd != 5'd0) begin
                        regs[rd] <= result;
                    end
                    retire_value   <= result;
                    retire_illegal <= 1'b0;
                end else begin
                    retire_value   <= '0;
                    retire_illegal <= 1'b1;
                end
            end
        end
    end

endmodule
